bus_simple_reg_slave: RTL and testbench

BUS_SIMPLE_REG_SLAVE -- requirements
Module: bus_simple_reg_slave

---
 rtl/bus_simple_pkg.sv | 37 +++
 rtl/bus_simple_reg_slave_if.sv | 35 +++
 rtl/bus_simple_regbank.sv | 93 +++++++++
 rtl/bus_simple_reg_slave.sv | 137 +++++++++++++
 tb/tb_bus_simple_reg_slave.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_simple_pkg.sv
// Shared definitions for the simple register slave: register offsets, FSM states and helpers.
package bus_simple_pkg;

    // Width of the interrupt status/enable registers (write-1-to-clear on IRQ_STAT).
    localparam int unsigned IrqWidth = 8;

    // Byte offsets inside the 64-byte register window.
    localparam logic [5:0] RegId       = 6'h00;
    localparam logic [5:0] RegCtrl     = 6'h04;
    localparam logic [5:0] RegStatus   = 6'h08;
    localparam logic [5:0] RegIrqStat  = 6'h0C;
    localparam logic [5:0] RegIrqEn    = 6'h10;
    localparam logic [5:0] RegScratch0 = 6'h14;
    localparam logic [5:0] RegScratch1 = 6'h18;
    localparam logic [5:0] RegScratch2 = 6'h1C;
    localparam logic [5:0] RegCycles   = 6'h20;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(logic [31:0] old_val, logic [31:0] new_val,
                                                logic [3:0] strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_simple_reg_slave_if.sv
// Request/response bus between a master and the simple register slave.
interface bus_simple_reg_slave_if;

    logic        m_valid;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport master (
        output m_valid,
        output m_write,
        output m_addr,
        output m_wdata,
        output m_wstrb,
        input  m_ready,
        input  m_rvalid,
        input  m_rdata
    );

    modport slave (
        input  m_valid,
        input  m_write,
        input  m_addr,
        input  m_wdata,
        input  m_wstrb,
        output m_ready,
        output m_rvalid,
        output m_rdata
    );

endinterface

// File: rtl/bus_simple_regbank.sv
// Register storage, interrupt logic, free-running cycle counter and combinational read mux.
module bus_simple_regbank
    import bus_simple_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'h534E_4E01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic                hit_i,
    input  logic [3:0]          idx_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          wstrb_i,
    input  logic [31:0]         status_i,
    input  logic [IrqWidth-1:0] irq_set_i,
    output logic [31:0]         rdata_o,
    output logic [31:0]         ctrl_o,
    output logic                irq_o
);

    logic [5:0]          off;
    logic [31:0]         ctrl_q, ctrl_d;
    logic [IrqWidth-1:0] irq_stat_q, irq_stat_d;
    logic [IrqWidth-1:0] irq_en_q, irq_en_d;
    logic [IrqWidth-1:0] irq_clr;
    logic [2:0][31:0]    scratch_q, scratch_d;
    logic [31:0]         cycles_q;
    logic                irq_q;

    assign off = {idx_i, 2'b00};

    // Next-state of writable registers; a set pulse wins over a same-cycle W1C clear.
    always_comb begin
        ctrl_d    = ctrl_q;
        irq_en_d  = irq_en_q;
        scratch_d = scratch_q;
        irq_clr   = '0;
        if (wr_en_i) begin
            case (off)
                RegCtrl:     ctrl_d = apply_wstrb(ctrl_q, wdata_i, wstrb_i);
                RegIrqStat:  if (wstrb_i[0]) irq_clr = wdata_i[IrqWidth-1:0];
                RegIrqEn:    if (wstrb_i[0]) irq_en_d = wdata_i[IrqWidth-1:0];
                RegScratch0: scratch_d[0] = apply_wstrb(scratch_q[0], wdata_i, wstrb_i);
                RegScratch1: scratch_d[1] = apply_wstrb(scratch_q[1], wdata_i, wstrb_i);
                RegScratch2: scratch_d[2] = apply_wstrb(scratch_q[2], wdata_i, wstrb_i);
                default:     ;
            endcase
        end
        irq_stat_d = (irq_stat_q & ~irq_clr) | irq_set_i;
    end

    // Register state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
            scratch_q  <= '0;
            cycles_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
            scratch_q  <= scratch_d;
            cycles_q   <= cycles_q + 32'd1;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    // Read mux; misses and unmapped offsets return zero.
    always_comb begin
        rdata_o = '0;
        if (hit_i) begin
            case (off)
                RegId:       rdata_o = ID_VALUE;
                RegCtrl:     rdata_o = ctrl_q;
                RegStatus:   rdata_o = status_i;
                RegIrqStat:  rdata_o = 32'(irq_stat_q);
                RegIrqEn:    rdata_o = 32'(irq_en_q);
                RegScratch0: rdata_o = scratch_q[0];
                RegScratch1: rdata_o = scratch_q[1];
                RegScratch2: rdata_o = scratch_q[2];
                RegCycles:   rdata_o = cycles_q;
                default:     rdata_o = '0;
            endcase
        end
    end

    assign ctrl_o = ctrl_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/bus_simple_reg_slave.sv
// Simple register slave: request FSM with optional wait states, address decode, register bank.
module bus_simple_reg_slave
    import bus_simple_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter logic [31:0] ID_VALUE    = 32'h534E_4E01,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bus_simple_reg_slave_if.slave bus,
    output logic [31:0]           ctrl_o,
    input  logic [31:0]           status_i,
    input  logic [IrqWidth-1:0]   irq_set_i,
    output logic                  irq_o
);

    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        ready_q, rvalid_q;
    logic [31:0] rdata_q;

    logic        enter_resp;
    logic        in_idle;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        hit;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] bank_rdata;
    logic        unused_addr_lsb;

    // FSM next state and request capture; enter_resp marks the commit/sample edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.m_valid) begin
                    write_d = bus.m_write;
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    wstrb_d = bus.m_wstrb;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With no wait states the commit edge is the accepting edge, so use the live request then.
    assign in_idle         = (state_q == StIdle);
    assign req_write       = in_idle ? bus.m_write : write_q;
    assign req_addr        = in_idle ? bus.m_addr  : addr_q;
    assign req_wdata       = in_idle ? bus.m_wdata : wdata_q;
    assign req_wstrb       = in_idle ? bus.m_wstrb : wstrb_q;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign hit   = (req_addr[31:6] == BASE_ADDR[31:6]);
    assign wr_en = enter_resp & req_write & hit;
    assign rd_en = enter_resp & ~req_write;

    // FSM state, captured request and registered response pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            ready_q  <= enter_resp;
            rvalid_q <= rd_en;
            rdata_q  <= rd_en ? bank_rdata : 32'h0;
        end
    end

    bus_simple_regbank #(
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .hit_i     (hit),
        .idx_i     (req_addr[5:2]),
        .wdata_i   (req_wdata),
        .wstrb_i   (req_wstrb),
        .status_i  (status_i),
        .irq_set_i (irq_set_i),
        .rdata_o   (bank_rdata),
        .ctrl_o    (ctrl_o),
        .irq_o     (irq_o)
    );

    assign bus.m_ready  = ready_q;
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_rdata  = rdata_q;

endmodule

// File: tb/tb_bus_simple_reg_slave.sv
// Bench for bus_simple_reg_slave: one instance with no wait states, one with three.
module tb_bus_simple_reg_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] IDV  = 32'h534E_4E01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] status;
    logic [7:0]  irq_set;
    logic [31:0] ctrl0, ctrl1;
    logic        irq0, irq1;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int rst_edge = 0;

    // Reference model state, one copy per instance.
    logic [31:0] m_ctrl [2];
    logic [31:0] m_scr  [2][3];
    logic [7:0]  m_stat [2];
    logic [7:0]  m_en   [2];

    bus_simple_reg_slave_if bus0 ();
    bus_simple_reg_slave_if bus1 ();

    bus_simple_reg_slave #(.BASE_ADDR(BASE), .ID_VALUE(IDV), .WAIT_STATES(0)) dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0), .ctrl_o (ctrl0),
        .status_i (status), .irq_set_i (irq_set), .irq_o (irq0)
    );

    bus_simple_reg_slave #(.BASE_ADDR(BASE), .ID_VALUE(IDV), .WAIT_STATES(3)) dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1), .ctrl_o (ctrl1),
        .status_i (status), .irq_set_i (irq_set), .irq_o (irq1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end expected end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? bus0.m_ready : bus1.m_ready;
    endfunction

    function automatic logic rvalid_of(input int d);
        return (d == 0) ? bus0.m_rvalid : bus1.m_rvalid;
    endfunction

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? bus0.m_rdata : bus1.m_rdata;
    endfunction

    function automatic logic [31:0] ctrl_of(input int d);
        return (d == 0) ? ctrl0 : ctrl1;
    endfunction

    function automatic logic irq_of(input int d);
        return (d == 0) ? irq0 : irq1;
    endfunction

    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
        if (d == 0) begin
            bus0.m_valid = v; bus0.m_write = w; bus0.m_addr = a;
            bus0.m_wdata = wd; bus0.m_wstrb = s;
        end else begin
            bus1.m_valid = v; bus1.m_write = w; bus1.m_addr = a;
            bus1.m_wdata = wd; bus1.m_wstrb = s;
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = '0; m_stat[k] = '0; m_en[k] = '0;
            for (int j = 0; j < 3; j++) m_scr[k][j] = '0;
        end
    endfunction

    // Expected read value; acc is the accepting edge index of the request.
    function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input int acc);
        int idx;
        if ((a & 32'hFFFF_FFC0) != BASE) return 32'h0;
        idx = int'(a[5:2]);
        case (idx)
            0: return IDV;
            1: return m_ctrl[d];
            2: return status;
            3: return {24'h0, m_stat[d]};
            4: return {24'h0, m_en[d]};
            5, 6, 7: return m_scr[d][idx-5];
            8: return 32'(acc + ws_of(d) - rst_edge - 1);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [3:0] s);
        int idx;
        if ((a & 32'hFFFF_FFC0) != BASE) return;
        idx = int'(a[5:2]);
        case (idx)
            1: m_ctrl[d] = merge(m_ctrl[d], wd, s);
            3: if (s[0]) m_stat[d] = m_stat[d] & ~wd[7:0];
            4: if (s[0]) m_en[d] = wd[7:0];
            5, 6, 7: m_scr[d][idx-5] = merge(m_scr[d][idx-5], wd, s);
            default: ;
        endcase
    endfunction

    // One transaction, started and ended on a falling edge. setp is an irq_set pulse sent
    // with the request; it is folded in after the write, which matches a zero-wait target.
    task automatic txn(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [7:0] setp, input string tag);
        logic [31:0] exp;
        int acc, lat;
        bit got;
        status = $urandom();
        drive(d, 1'b1, wr, a, wd, s);
        irq_set = setp;
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        irq_set = '0;
        acc = edge_n;
        exp = wr ? 32'h0 : model_read(d, a, acc);
        got = 0;
        lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (ready_of(d)) begin
                got = 1;
                lat = c;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, " latency"}, lat, ws_of(d) + 1);
        if (wr) model_write(d, a, wd, s);
        for (int k = 0; k < 2; k++) m_stat[k] = m_stat[k] | setp;
        check({tag, " rvalid"}, rvalid_of(d), !wr);
        check({tag, " rdata"}, rdata_of(d), exp);
        check({tag, " ctrl_o"}, ctrl_of(d), m_ctrl[d]);
        @(negedge clk);
        check({tag, " ready end"}, ready_of(d), 1'b0);
        check({tag, " rvalid end"}, rvalid_of(d), 1'b0);
        check({tag, " rdata idle"}, rdata_of(d), 32'h0);
        check({tag, " irq_o"}, irq_of(d), |(m_stat[d] & m_en[d]));
    endtask

    initial begin
        int pulses;
        logic [31:0] a;
        rst_n = 1'b0;
        status = '0;
        irq_set = '0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_edge = edge_n;
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            check("reset ready", ready_of(d), 1'b0);
            check("reset rvalid", rvalid_of(d), 1'b0);
            check("reset rdata", rdata_of(d), 32'h0);
            check("reset ctrl_o", ctrl_of(d), 32'h0);
            check("reset irq_o", irq_of(d), 1'b0);
        end

        // ID read with no wait states, then strobed scratch write and read-back.
        txn(0, 1'b0, BASE, 32'h0, 4'h0, 8'h0, "id read");
        txn(0, 1'b1, BASE + 32'h14, 32'hAABB_CCDD, 4'b0101, 8'h0, "scratch0 wr");
        txn(0, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 8'h0, "scratch0 rd");
        check("scratch0 const", m_scr[0][0], 32'h00BB_00DD);

        // Three wait states: CTRL write responds four cycles after acceptance.
        txn(1, 1'b1, BASE + 32'h04, 32'h1, 4'hF, 8'h0, "ctrl ws3");
        check("ctrl ws3 value", ctrl1, 32'h1);

        // A request during WAIT is dropped.
        drive(1, 1'b1, 1'b1, BASE + 32'h14, 32'h1111_1111, 4'hF);
        @(negedge clk);
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            if (bus1.m_ready) pulses++;
            if (c == 2) drive(1, 1'b1, 1'b1, BASE + 32'h18, 32'h2222_2222, 4'hF);
            else drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
        end
        check("busy pulses", pulses, 1);
        m_scr[1][0] = 32'h1111_1111;
        txn(1, 1'b0, BASE + 32'h18, 32'h0, 4'h0, 8'h0, "dropped rd");
        txn(1, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 8'h0, "accepted rd");

        // Interrupt: enable bit 2, pulse set, registered irq_o, set wins over clear.
        txn(0, 1'b1, BASE + 32'h10, 32'h4, 4'h1, 8'h0, "irq en");
        irq_set = 8'h04;
        @(negedge clk);
        irq_set = 8'h00;
        m_stat[0] = m_stat[0] | 8'h04;
        m_stat[1] = m_stat[1] | 8'h04;
        check("irq delay", irq0, 1'b0);
        @(negedge clk);
        check("irq high", irq0, 1'b1);
        txn(0, 1'b1, BASE + 32'h0C, 32'h4, 4'h1, 8'h04, "w1c vs set");
        check("set wins", m_stat[0], 8'h04);
        txn(0, 1'b0, BASE + 32'h0C, 32'h0, 4'h0, 8'h0, "irq stat rd");
        txn(0, 1'b1, BASE + 32'h0C, 32'h4, 4'h1, 8'h0, "w1c clear");
        @(negedge clk);
        check("irq low", irq0, 1'b0);

        // Miss, unmapped index and write to read-only ID.
        txn(0, 1'b0, 32'h5000_0000, 32'h0, 4'h0, 8'h0, "miss rd");
        txn(0, 1'b0, BASE + 32'h24, 32'h0, 4'h0, 8'h0, "unmapped rd");
        txn(0, 1'b1, BASE, 32'hFFFF_FFFF, 4'hF, 8'h0, "ro wr");
        txn(0, 1'b0, BASE, 32'h0, 4'h0, 8'h0, "id after wr");

        // Reset during WAIT aborts the write and gives no response.
        drive(1, 1'b1, 1'b1, BASE + 32'h04, 32'h55, 4'hF);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b0;
        pulses = 0;
        for (int c = 0; c < 2; c++) begin
            if (bus1.m_ready || bus1.m_rvalid) pulses++;
            @(negedge clk);
        end
        rst_edge = edge_n;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            if (bus1.m_ready || bus1.m_rvalid) pulses++;
            @(negedge clk);
        end
        check("abort pulses", pulses, 0);
        check("abort ctrl1", ctrl1, 32'h0);
        check("abort irq1", irq1, 1'b0);
        txn(1, 1'b0, BASE + 32'h04, 32'h0, 4'h0, 8'h0, "ctrl after rst");
        txn(1, 1'b0, BASE, 32'h0, 4'h0, 8'h0, "id after rst");
        txn(0, 1'b0, BASE + 32'h14, 32'h0, 4'h0, 8'h0, "scr0 after rst");
        txn(1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 8'h0, "cycles rd");

        // Random traffic on both instances against the model.
        for (int n = 0; n < 80; n++) begin
            a = BASE | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a ^ (32'h1 << $urandom_range(6, 31));
            txn(n % 2, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), 8'h0,
                "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
